alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared 16-bit ALU: IDLE -> EXEC -> RESP.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] rs0,
  input  logic [15:0] rt0,
  input  logic [15:0] rs1,
  input  logic [15:0] rt1,
  input  logic [4:0]  instr0,
  input  logic [4:0]  instr1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        valid0,
  output logic        valid1,
  output logic [15:0] result,
  output logic        err_out,
  output logic        busy,
  output logic [15:0] alu_rs,
  output logic [15:0] alu_rt,
  output logic [4:0]  alu_instr,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_rd,
  input  logic        alu_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        own;
  logic        win1;
  logic        any;
  logic [15:0] rs_q;
  logic [15:0] rt_q;
  logic [4:0]  instr_q;
  logic [1:0]  op_q;

  assign any = req0 | req1;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // ptr high: requester 1 has priority on a tie
  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (state == IDLE && any)
      ptr <= ~win1;
  end

  assign win1 = req1 & (~req0 | ptr);
`else
  assign win1 = req1 & ~req0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      own     <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      valid0  <= 1'b0;
      valid1  <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
      err_out <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      instr_q <= '0;
      op_q    <= '0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            state   <= EXEC;
            busy    <= 1'b1;
            own     <= win1;
            gnt0    <= ~win1;
            gnt1    <= win1;
            rs_q    <= win1 ? rs1 : rs0;
            rt_q    <= win1 ? rt1 : rt0;
            instr_q <= win1 ? instr1 : instr0;
            op_q    <= win1 ? op1 : op0;
          end
        end
        EXEC: begin
          state   <= RESP;
          result  <= alu_rd;
          err_out <= alu_err;
          valid0  <= ~own;
          valid1  <= own;
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_rs    = rs_q;
  assign alu_rt    = rt_q;
  assign alu_instr = instr_q;
  assign alu_op    = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU
// (instr 3 = add, instr 4 = equality compare).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] rs0 = '0;
  logic [15:0] rt0 = '0;
  logic [15:0] rs1 = '0;
  logic [15:0] rt1 = '0;
  logic [4:0]  instr0 = '0;
  logic [4:0]  instr1 = '0;
  logic [1:0]  op0 = '0;
  logic [1:0]  op1 = '0;
  logic        gnt0, gnt1, valid0, valid1, err_out, busy;
  logic [15:0] result, alu_rs, alu_rt;
  logic [4:0]  alu_instr;
  logic [1:0]  alu_op;
  logic [15:0] alu_rd;
  logic        alu_err;
  logic        force_err = 1'b0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    alu_rd = '0;
    if (alu_instr == 5'd3)
      alu_rd = alu_rs + alu_rt;
    else if (alu_instr == 5'd4)
      alu_rd = {15'b0, alu_rs == alu_rt};
  end

  assign alu_err = force_err;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .rs0(rs0), .rt0(rt0), .rs1(rs1), .rt1(rt1),
    .instr0(instr0), .instr1(instr1),
    .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1),
    .valid0(valid0), .valid1(valid1),
    .result(result), .err_out(err_out), .busy(busy),
    .alu_rs(alu_rs), .alu_rt(alu_rt),
    .alu_instr(alu_instr), .alu_op(alu_op),
    .alu_rd(alu_rd), .alu_err(alu_err)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single request through the full IDLE-EXEC-RESP sequence.
  task automatic run_op(input bit who, input logic [15:0] exp_res,
                        input bit exp_err, input bit chg);
    if (who) req1 = 1'b1;
    else     req0 = 1'b1;
    tick();
    check("gnt0", {15'b0, gnt0}, {15'b0, ~who});
    check("gnt1", {15'b0, gnt1}, {15'b0, who});
    check("busy_exec", {15'b0, busy}, 16'd1);
    check("valid_exec", {14'b0, valid1, valid0}, 16'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    if (chg) rs0 = 16'hFFFF;
    tick();
    check("valid0", {15'b0, valid0}, {15'b0, ~who});
    check("valid1", {15'b0, valid1}, {15'b0, who});
    check("gnt_resp", {14'b0, gnt1, gnt0}, 16'd0);
    check("result", result, exp_res);
    check("err_out", {15'b0, err_out}, {15'b0, exp_err});
    tick();
    check("busy_idle", {15'b0, busy}, 16'd0);
    check("valid_idle", {14'b0, valid1, valid0}, 16'd0);
    check("result_hold", result, exp_res);
  endtask

  initial begin
    bit w;
    tick();
    tick();
    check("rst_busy", {15'b0, busy}, 16'd0);
    check("rst_gnt", {14'b0, gnt1, gnt0}, 16'd0);
    check("rst_valid", {14'b0, valid1, valid0}, 16'd0);
    check("rst_result", result, 16'd0);
    check("rst_err", {15'b0, err_out}, 16'd0);
    check("rst_alu_rs", alu_rs, 16'd0);
    rst_n = 1'b1;

    // Both requesters held high for four grants.
    rs0 = 16'd1; rt0 = 16'd2; instr0 = 5'd3;
    rs1 = 16'd5; rt1 = 16'd5; instr1 = 5'd4;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      w = i[0];
`else
      w = 1'b0;
`endif
      tick();
      check("rr_gnt0", {15'b0, gnt0}, {15'b0, ~w});
      check("rr_gnt1", {15'b0, gnt1}, {15'b0, w});
      tick();
      check("rr_valid0", {15'b0, valid0}, {15'b0, ~w});
      check("rr_valid1", {15'b0, valid1}, {15'b0, w});
      check("rr_result", result, w ? 16'd1 : 16'd3);
      tick();
      check("rr_idle", {15'b0, busy}, 16'd0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();

    rs0 = 16'h0003; rt0 = 16'h0004; instr0 = 5'b00011; op0 = 2'b00;
    run_op(1'b0, 16'h0007, 1'b0, 1'b0);

    rs1 = 16'h1234; rt1 = 16'h1234; instr1 = 5'b00100;
    run_op(1'b1, 16'h0001, 1'b0, 1'b0);
    rt1 = 16'h1235;
    run_op(1'b1, 16'h0000, 1'b0, 1'b0);

    rs0 = 16'h0010; rt0 = 16'h0020;
    run_op(1'b0, 16'h0030, 1'b0, 1'b1);

    rs0 = 16'h0003; rt0 = 16'h0004;
    force_err = 1'b1;
    run_op(1'b0, 16'h0007, 1'b1, 1'b0);
    force_err = 1'b0;
    run_op(1'b0, 16'h0007, 1'b0, 1'b0);

    // Reset while the operation is in EXEC.
    rs0 = 16'h0100; rt0 = 16'h0001;
    req0 = 1'b1;
    tick();
    check("mid_gnt0", {15'b0, gnt0}, 16'd1);
    rst_n = 1'b0;
    tick();
    check("mid_busy", {15'b0, busy}, 16'd0);
    check("mid_result", result, 16'd0);
    check("mid_valid", {14'b0, valid1, valid0}, 16'd0);
    rst_n = 1'b1;
    tick();
    check("mid_regnt", {15'b0, gnt0}, 16'd1);
    req0 = 1'b0;
    tick();
    check("mid_revalid", {14'b0, valid1, valid0}, 16'd1);
    check("mid_reresult", result, 16'h0101);
    tick();
    check("mid_idle", {15'b0, busy}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
